mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 110 +++++++++++
 tb/tb_mem_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port word memory behind a req/ready handshake with a fixed response latency.
// Each accepted request is serviced once; req is ignored until the responder is idle again.
module mem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        addr_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic [31:0]           addr_q;
  logic [31:0]           wdata_q;
  logic                  write_q;
  logic [31:0]           rdata_q;
  logic                  ready_q;
  logic                  addr_err_q;
  logic [31:0]           mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  access_now;
  logic                  access_err;

  assign word_idx   = addr_q[DEPTH_LOG2+1:2];
  assign access_now = (state_q == WAIT) && (cnt_q == 4'd0);
  // Anything above the stored range, or not word aligned, is rejected.
  assign access_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (DEPTH_LOG2 + 2)) != 32'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      write_q    <= 1'b0;
      rdata_q    <= 32'd0;
      ready_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q    <= 1'b0;
          addr_err_q <= 1'b0;
          if (req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            write_q <= mem_write;
            cnt_q   <= 4'(LATENCY - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            ready_q <= 1'b1;
            state_q <= RESP;
            if (access_err) begin
              rdata_q    <= 32'd0;
              addr_err_q <= 1'b1;
            end else begin
              addr_err_q <= 1'b0;
              if (!write_q) begin
                rdata_q <= mem_q[word_idx];
              end
            end
          end
        end
        RESP: begin
          ready_q    <= 1'b0;
          addr_err_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          ready_q    <= 1'b0;
          addr_err_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  // Array has no reset; a reset mid-flight returns state_q to IDLE so the write never fires.
  always_ff @(posedge clk) begin
    if (access_now && write_q && !access_err) begin
      mem_q[word_idx] <= wdata_q;
    end
  end

  assign rdata    = rdata_q;
  assign ready    = ready_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a word-array reference model.
// Each access is followed edge by edge until the response window has passed.
module tb_mem_responder;
  parameter int LATENCY = 2;
  localparam int DL2 = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        addr_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] ref_rdata;
  bit          ref_rdata_known;

  mem_responder #(.DEPTH_LOG2(DL2), .LATENCY(LATENCY)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .mem_write(mem_write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (DL2 + 2)) != 32'd0);
  endfunction

  // mode 0: quiet inputs after acceptance; 1: random input noise; 2: addr moved to 0xC
  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d, input int mode);
    bit err;
    int idx;
    err = is_err(a);
    idx = int'(a[DL2+1:2]);
    @(negedge clk);
    req = 1'b1; mem_write = wr; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0;
    if (err) begin
      ref_rdata = 32'd0;
      ref_rdata_known = 1'b1;
    end else if (wr) begin
      ref_mem[idx] = d;
    end else if (ref_mem.exists(idx)) begin
      ref_rdata = ref_mem[idx];
      ref_rdata_known = 1'b1;
    end else begin
      ref_rdata_known = 1'b0;
    end
    for (int k = 1; k <= LATENCY + 1; k++) begin
      if (mode == 1) begin
        req = 1'(($urandom % 2));
        mem_write = 1'(($urandom % 2));
        addr = $urandom;
        wdata = $urandom;
      end else if (mode == 2) begin
        addr = 32'h0000000C;
      end
      @(posedge clk);
      #1;
      check("ready", {31'd0, ready}, 32'(k == LATENCY));
      if (k == LATENCY) begin
        check("addr_err", {31'd0, addr_err}, 32'(err));
        if (ref_rdata_known) check("rdata", rdata, ref_rdata);
      end else begin
        check("addr_err_quiet", {31'd0, addr_err}, 32'd0);
      end
    end
    req = 1'b0;
    $display("txn wr=%0d addr=%h wdata=%h rdata=%h err=%0b", wr, a, d, rdata, err);
  endtask

  initial begin
    logic [31:0] a;
    int r;
    reset = 1'b0; req = 1'b0; mem_write = 1'b0; addr = 32'd0; wdata = 32'd0;
    ref_rdata = 32'd0;
    ref_rdata_known = 1'b1;
    #1;
    check("reset_rdata", rdata, 32'd0);
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_addr_err", {31'd0, addr_err}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Directed: write/read back, error cases, out-of-range write is harmless
    access(1'b1, 32'h10, 32'hDEADBEEF, 0);
    access(1'b0, 32'h10, 32'h0, 0);
    access(1'b1, 32'h0, 32'hA5A5_0000, 0);
    access(1'b0, 32'h11, 32'h0, 0);
    access(1'b0, 32'h400, 32'h0, 0);
    access(1'b1, 32'h400, 32'h1111_2222, 0);
    access(1'b0, 32'h0, 32'h0, 0);

    // Late address change must not redirect an in-flight read
    access(1'b1, 32'h8, 32'h0000_0222, 0);
    access(1'b1, 32'hC, 32'h0000_0333, 0);
    access(1'b0, 32'h8, 32'h0, 2);

    // Continuously held req: one acceptance every LATENCY+2 edges
    access(1'b1, 32'h20, 32'hCAFE_F00D, 0);
    @(negedge clk);
    req = 1'b1; mem_write = 1'b0; addr = 32'h20; wdata = 32'h0;
    ref_rdata = ref_mem[8];
    ref_rdata_known = 1'b1;
    for (int k = 0; k < 3 * (LATENCY + 2); k++) begin
      @(posedge clk);
      #1;
      check("held_ready", {31'd0, ready}, 32'((k % (LATENCY + 2)) == LATENCY));
      if (ready) check("held_rdata", rdata, ref_rdata);
    end
    req = 1'b0;
    $display("txn held-req reads of 0x20 done, %0d accesses", 3);

    // Reset during WAIT drops the pending write
    access(1'b1, 32'h0, 32'h12345678, 0);
    @(negedge clk);
    req = 1'b1; mem_write = 1'b1; addr = 32'h0; wdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    req = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check("rst_mid_rdata", rdata, 32'd0);
    check("rst_mid_ready", {31'd0, ready}, 32'd0);
    check("rst_mid_addr_err", {31'd0, addr_err}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ref_rdata = 32'd0;
    ref_rdata_known = 1'b1;
    for (int k = 0; k < LATENCY + 2; k++) begin
      @(posedge clk);
      #1;
      check("rst_no_ready", {31'd0, ready}, 32'd0);
    end
    $display("txn reset dropped write of ffffffff to 0x0");
    access(1'b0, 32'h0, 32'h0, 0);

    // Randomized traffic with input noise during the wait window
    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (r == 1) a = $urandom | 32'h0000_0400;
      else if (r == 2) a = 32'($urandom_range(0, 255) * 4);
      else a = 32'($urandom_range(0, 15) * 4);
      access(1'(($urandom % 2)), a, $urandom, int'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
